dm_arbiter: RTL and testbench

- Shares the single-port data memory (`memory`) between two requesters: r0 is the core load/store unit and r1 is the debug/loader port.
- Arbitrates round-robin, sequences each access through the memory's 1-cycle registered read, routes read data back to the owner and flags out-of-range addresses.
- Sits between the core/debug logic and the data memory. It drives all memory command inputs except the memory's own reset.

---
 rtl/dm_arb_pkg.sv | 16 +
 rtl/dm_arbiter_rr_arb2.sv | 26 ++
 rtl/dm_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam owner_t      OWNER_R0 = 1'b0;
    localparam owner_t      OWNER_R1 = 1'b1;
    localparam int unsigned DM_DEPTH = 1024;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that did not own the previous access.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic [1:0] gnt,
    output owner_t     winner
);

    always_comb begin
        winner = OWNER_R0;
        gnt    = 2'b00;
        case (req)
            2'b01:   winner = OWNER_R0;
            2'b10:   winner = OWNER_R1;
            2'b11:   winner = ~last_owner;
            default: winner = OWNER_R0;
        endcase
        if (req != 2'b00) begin
            gnt = (winner == OWNER_R1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares one single-port data memory between the core LSU (r0) and the
// debug/loader port (r1); sequences each access and routes the response.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = DM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdat,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdat,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_dat,
    output logic              rd_en,
    output logic              wr_en,
    input  logic [DATA_W-1:0] m_rd_dat
);

    // One extra bit keeps the compare unsigned and full-width for any ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    owner_t            last_owner_q, last_owner_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wr_dat_q, m_wr_dat_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;

    logic [1:0]        arb_gnt;
    owner_t            arb_winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdat;
    logic              sel_in_range;
    logic              resp_done;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    rr_arb2 u_rr_arb2 (
        .req        ({r1_req, r0_req}),
        .last_owner (last_owner_q),
        .gnt        (arb_gnt),
        .winner     (arb_winner)
    );

    assign sel_we       = (arb_winner == OWNER_R1) ? r1_we   : r0_we;
    assign sel_addr     = (arb_winner == OWNER_R1) ? r1_addr : r0_addr;
    assign sel_wdat     = (arb_winner == OWNER_R1) ? r1_wdat : r0_wdat;
    assign sel_in_range = ({1'b0, sel_addr} < DEPTH_W);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        err_d        = err_q;
        m_addr_d     = m_addr_q;
        m_wr_dat_d   = m_wr_dat_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        r0_gnt       = 1'b0;
        r1_gnt       = 1'b0;
        resp_done    = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = '0;

        case (state_q)
            IDLE: begin
                // Grants are masked while reset is held so none leak out.
                r0_gnt = arb_gnt[0] & reset;
                r1_gnt = arb_gnt[1] & reset;
                if (arb_gnt != 2'b00) begin
                    owner_d      = arb_winner;
                    last_owner_d = arb_winner;
                    we_d         = sel_we;
                    err_d        = ~sel_in_range;
                    state_d      = ISSUE;
                    if (sel_in_range) begin
                        m_addr_d   = sel_addr;
                        m_wr_dat_d = sel_wdat;
                        wr_en_d    = sel_we;
                        rd_en_d    = ~sel_we;
                    end else begin
                        wr_en_d    = 1'b0;
                        rd_en_d    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                if (we_q || err_q) begin
                    resp_done = 1'b1;
                    resp_err  = err_q;
                    state_d   = IDLE;
                end else begin
                    state_d   = RESP;
                end
            end
            RESP: begin
                resp_done  = 1'b1;
                resp_rdata = m_rd_dat;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_R1;
            owner_q      <= OWNER_R0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            m_addr_q     <= '0;
            m_wr_dat_q   <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            err_q        <= err_d;
            m_addr_q     <= m_addr_d;
            m_wr_dat_q   <= m_wr_dat_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
        end
    end

    assign r0_done  = resp_done & (owner_q == OWNER_R0);
    assign r1_done  = resp_done & (owner_q == OWNER_R1);
    assign r0_err   = resp_err  & (owner_q == OWNER_R0);
    assign r1_err   = resp_err  & (owner_q == OWNER_R1);
    assign r0_rdata = (owner_q == OWNER_R0) ? resp_rdata : '0;
    assign r1_rdata = (owner_q == OWNER_R1) ? resp_rdata : '0;

    assign m_addr   = m_addr_q;
    assign m_wr_dat = m_wr_dat_q;
    assign rd_en    = rd_en_q;
    assign wr_en    = wr_en_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: drives both requesters against a simple memory and a
// reference model of memory contents, grant order and completion latency.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdat, r1_addr, r1_wdat;
    logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] m_addr, m_wr_dat;
    logic        rd_en, wr_en;
    logic [31:0] m_rd_dat = 32'h0;

    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [logic [31:0]];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_last = 1;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdat(r0_wdat),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdat(r1_wdat),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .m_addr(m_addr), .m_wr_dat(m_wr_dat), .rd_en(rd_en), .wr_en(wr_en),
        .m_rd_dat(m_rd_dat)
    );

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (wr_en) mem[m_addr[9:0]] <= m_wr_dat;
        if (rd_en) m_rd_dat <= mem[m_addr[9:0]];
    end

    always @(negedge clk) begin
        if (reset) begin
            n_tests++;
            if ((rd_en && wr_en) || (r0_gnt && r1_gnt) || (r0_done && r1_done)) begin
                n_fail++;
                $display("FAIL exclusivity: got rd_en=%b wr_en=%b gnt=%b%b done=%b%b required no overlap",
                         rd_en, wr_en, r1_gnt, r0_gnt, r1_done, r0_done);
            end
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Drives one uncontended access and records what was observed; starts and
    // ends just after a rising edge.
    task automatic run_txn(input int who, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdat, output int gcyc, output int lat,
                           output logic err, output logic [31:0] rdata, output logic other_act,
                           output logic saw_rd, output logic saw_wr,
                           output logic [31:0] cmd_addr, output logic [31:0] cmd_dat);
        logic g;
        gcyc = 0; lat = -1; err = 0; rdata = 0; other_act = 0;
        saw_rd = 0; saw_wr = 0; cmd_addr = 0; cmd_dat = 0; g = 0;
        if (who == 0) begin r0_we = we; r0_addr = addr; r0_wdat = wdat; r0_req = 1; end
        else          begin r1_we = we; r1_addr = addr; r1_wdat = wdat; r1_req = 1; end
        while (!g && gcyc < 20) begin
            @(negedge clk);
            gcyc++;
            g = (who == 0) ? r0_gnt : r1_gnt;
            if (!g) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        r0_req = 0; r1_req = 0;
        if (g) begin
            model_last = who;
            for (int k = 1; k <= 4 && lat < 0; k++) begin
                @(negedge clk);
                if (rd_en) begin saw_rd = 1; cmd_addr = m_addr; end
                if (wr_en) begin saw_wr = 1; cmd_addr = m_addr; cmd_dat = m_wr_dat; end
                if (who == 0) begin
                    if (r1_gnt || r1_done || r1_rdata != 0) other_act = 1;
                    if (r0_done) begin lat = k; err = r0_err; rdata = r0_rdata; end
                end else begin
                    if (r0_gnt || r0_done || r0_rdata != 0) other_act = 1;
                    if (r1_done) begin lat = k; err = r1_err; rdata = r1_rdata; end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 0;
        r0_req = 1; r1_req = 1; r0_we = 0; r1_we = 0;
        r0_addr = 0; r1_addr = 0; r0_wdat = 0; r1_wdat = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, rd_en, wr_en} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, rd_en, wr_en});
        end
        n_tests++;
        if ({m_addr, m_wr_dat, r0_rdata, r1_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h required all 0", m_addr, m_wr_dat, r0_rdata, r1_rdata);
        end
        r0_req = 0; r1_req = 0;
        @(posedge clk); #1;
        reset = 1; model_last = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int gc, lat; logic err, oa, srd, swr; logic [31:0] rd, ca, cd;
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, gc, lat, err, rd, oa, srd, swr, ca, cd);
        ref_mem[32'h10] = 32'hDEADBEEF;
        n_tests++;
        if (gc !== 1 || lat !== 1) begin n_fail++; $display("FAIL wr_timing: got gnt@%0d done@+%0d required 1/1", gc, lat); end
        n_tests++;
        if (err !== 0 || swr !== 1 || srd !== 0 || ca !== 32'h10 || cd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_cmd: got err=%b wr=%b rd=%b a=%h d=%h required 0 1 0 10 deadbeef", err, swr, srd, ca, cd);
        end
        n_tests++;
        if (mem[10'h10] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem: got %h required deadbeef", mem[10'h10]); end
    endtask

    task automatic test_read();
        int gc, lat; logic err, oa, srd, swr; logic [31:0] rd, ca, cd;
        run_txn(1, 1'b0, 32'h10, 32'h0, gc, lat, err, rd, oa, srd, swr, ca, cd);
        n_tests++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || err !== 0) begin
            n_fail++; $display("FAIL rd_resp: got lat=%0d data=%h err=%b required 2 deadbeef 0", lat, rd, err);
        end
        n_tests++;
        if (oa !== 0 || srd !== 1 || swr !== 0 || ca !== 32'h10) begin
            n_fail++; $display("FAIL rd_cmd: got other=%b rd=%b wr=%b a=%h required 0 1 0 10", oa, srd, swr, ca);
        end
    endtask

    task automatic test_contention();
        int gc, lat, cyc, g, expw, i0, i1, d0, d1; logic err, oa, srd, swr; logic [31:0] rd, ca, cd;
        logic [31:0] a0 [2]; logic [31:0] a1 [2]; int order[$];
        a0[0] = 32'h1; a0[1] = 32'h3; a1[0] = 32'h2; a1[1] = 32'h4;
        for (int k = 1; k <= 4; k++) begin
            cd = $urandom;
            run_txn((k % 2 == 1) ? 0 : 1, 1'b1, k, cd, gc, lat, err, rd, oa, srd, swr, ca, cd);
            ref_mem[k] = cd;
        end
        cyc = 0; i0 = 0; i1 = 0; d0 = 0; d1 = 0;
        r0_we = 0; r0_addr = a0[0]; r0_req = 1;
        r1_we = 0; r1_addr = a1[0]; r1_req = 1;
        while ((d0 < 2 || d1 < 2) && cyc < 40) begin
            @(negedge clk); cyc++;
            if (r0_done) begin
                n_tests++;
                if (r0_rdata !== ref_rd(a0[d0 % 2])) begin n_fail++; $display("FAIL cont_r0_data: got %h required %h", r0_rdata, ref_rd(a0[d0 % 2])); end
                d0++;
            end
            if (r1_done) begin
                n_tests++;
                if (r1_rdata !== ref_rd(a1[d1 % 2])) begin n_fail++; $display("FAIL cont_r1_data: got %h required %h", r1_rdata, ref_rd(a1[d1 % 2])); end
                d1++;
            end
            g = r0_gnt ? 0 : (r1_gnt ? 1 : -1);
            if (g >= 0) begin
                expw = (r0_req && r1_req) ? 1 - model_last : (r0_req ? 0 : 1);
                n_tests++;
                if (g !== expw) begin n_fail++; $display("FAIL cont_winner: got r%0d required r%0d", g, expw); end
                model_last = g;
                order.push_back(g);
            end
            @(posedge clk); #1;
            if (g == 0) begin i0++; if (i0 < 2) r0_addr = a0[i0]; else r0_req = 0; end
            if (g == 1) begin i1++; if (i1 < 2) r1_addr = a1[i1]; else r1_req = 0; end
        end
        r0_req = 0; r1_req = 0;
        n_tests++;
        if (cyc >= 40 || order.size() != 4) begin
            n_fail++; $display("FAIL cont_complete: got %0d grants in %0d cycles required 4", order.size(), cyc);
        end else if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            n_fail++; $display("FAIL cont_order: got %0d%0d%0d%0d required 0101", order[0], order[1], order[2], order[3]);
        end
    endtask

    task automatic test_out_of_range();
        int gc, lat; logic err, oa, srd, swr; logic [31:0] rd, ca, cd;
        run_txn(0, 1'b0, 32'd1024, 32'h0, gc, lat, err, rd, oa, srd, swr, ca, cd);
        n_tests++;
        if (lat !== 1 || err !== 1 || rd !== 0 || srd !== 0 || swr !== 0) begin
            n_fail++; $display("FAIL oor_read: got lat=%0d err=%b data=%h rd=%b wr=%b required 1 1 0 0 0", lat, err, rd, srd, swr);
        end
        run_txn(1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, gc, lat, err, rd, oa, srd, swr, ca, cd);
        n_tests++;
        if (lat !== 1 || err !== 1 || swr !== 0 || mem[10'h3FF] !== ref_rd(32'd1023)) begin
            n_fail++; $display("FAIL oor_write: got lat=%0d err=%b wr=%b mem=%h required 1 1 0 %h", lat, err, swr, mem[10'h3FF], ref_rd(32'd1023));
        end
        run_txn(0, 1'b0, 32'd1023, 32'h0, gc, lat, err, rd, oa, srd, swr, ca, cd);
        n_tests++;
        if (lat !== 2 || err !== 0 || srd !== 1 || rd !== ref_rd(32'd1023)) begin
            n_fail++; $display("FAIL last_word: got lat=%0d err=%b rd=%b data=%h required 2 0 1 %h", lat, err, srd, rd, ref_rd(32'd1023));
        end
    endtask

    task automatic test_back_to_back();
        int gcyc[$]; int cyc; logic g, got; logic [31:0] d, rd;
        d = $urandom; cyc = 0; got = 0; rd = 0;
        r0_req = 1; r0_we = 1; r0_addr = 32'h30; r0_wdat = d;
        while (gcyc.size() < 3 && cyc < 30) begin
            @(negedge clk); cyc++;
            g = r0_gnt;
            if (g) gcyc.push_back(cyc);
            @(posedge clk); #1;
            if (g) begin
                model_last = 0;
                r0_we = 0;
                if (gcyc.size() == 3) r0_req = 0;
            end
        end
        r0_req = 0;
        ref_mem[32'h30] = d;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (r0_done) begin got = 1; rd = r0_rdata; end
        end
        @(posedge clk); #1;
        n_tests++;
        if (gcyc.size() != 3) begin
            n_fail++; $display("FAIL b2b_grants: got %0d grants required 3", gcyc.size());
        end else if (gcyc[1] - gcyc[0] != 2 || gcyc[2] - gcyc[1] != 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d/%0d required 2/3", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]);
        end
        n_tests++;
        if (got !== 1 || rd !== d) begin n_fail++; $display("FAIL b2b_data: got done=%b data=%h required 1 %h", got, rd, d); end
    endtask

    task automatic test_drop();
        logic bad;
        r0_req = 1; r0_we = 0; r0_addr = 32'h10;
        @(negedge clk);
        n_tests++;
        if (r0_gnt !== 1) begin n_fail++; $display("FAIL drop_gnt0: got %b required 1", r0_gnt); end
        @(posedge clk); #1;
        r0_req = 0; model_last = 0;
        @(negedge clk);
        @(posedge clk); #1;
        r1_req = 1; r1_we = 1; r1_addr = 32'h20; r1_wdat = 32'hBAD0BAD0;
        @(negedge clk);
        n_tests++;
        if (r0_done !== 1 || r0_rdata !== ref_rd(32'h10) || r1_gnt !== 0) begin
            n_fail++; $display("FAIL drop_resp: got done=%b data=%h r1_gnt=%b required 1 %h 0", r0_done, r0_rdata, r1_gnt, ref_rd(32'h10));
        end
        @(posedge clk); #1;
        r1_req = 0; bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (r1_gnt || r1_done || rd_en || wr_en) bad = 1;
        end
        @(posedge clk); #1;
        n_tests++;
        if (bad !== 0 || mem[10'h20] !== ref_rd(32'h20)) begin
            n_fail++; $display("FAIL drop_noaccess: got act=%b mem=%h required 0 %h", bad, mem[10'h20], ref_rd(32'h20));
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        r0_req = 1; r0_we = 0; r0_addr = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        r0_req = 0;
        @(negedge clk);
        n_tests++;
        if (rd_en !== 1) begin n_fail++; $display("FAIL mid_issue: got rd_en=%b required 1", rd_en); end
        #1 reset = 0;
        #1;
        n_tests++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, rd_en, wr_en} !== 8'h0 ||
            m_addr !== 0 || m_wr_dat !== 0 || r0_rdata !== 0) begin
            n_fail++; $display("FAIL mid_reset: got ctl=%b a=%h d=%h rdata=%h required all 0",
                               {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, rd_en, wr_en}, m_addr, m_wr_dat, r0_rdata);
        end
        @(posedge clk); #1;
        reset = 1; model_last = 1; bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (r0_done || r1_done || rd_en) bad = 1;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL mid_nodone: got activity=%b required 0", bad); end
        @(posedge clk); #1;
        r0_req = 1; r0_we = 0; r0_addr = 32'h1;
        r1_req = 1; r1_we = 0; r1_addr = 32'h2;
        @(negedge clk);
        n_tests++;
        if (r0_gnt !== 1 || r1_gnt !== 0) begin n_fail++; $display("FAIL mid_first_gnt: got r0=%b r1=%b required 1 0", r0_gnt, r1_gnt); end
        @(posedge clk); #1;
        r0_req = 0; r1_req = 0; model_last = 0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_random();
        int gc, lat, who, elat; logic we, oor, err, oa, srd, swr; logic [31:0] addr, wdat, rd, ca, cd, erd;
        for (int i = 0; i < 40; i++) begin
            who = $urandom_range(0, 1);
            we  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0, 1, 2: addr = $urandom_range(0, 15);
                3:       addr = 32'd1023;
                4:       addr = 32'd1024;
                default: addr = $urandom | 32'h0000_0400;
            endcase
            wdat = $urandom;
            oor  = (addr >= 32'd1024);
            elat = (we || oor) ? 1 : 2;
            erd  = (!we && !oor) ? ref_rd(addr) : 32'h0;
            run_txn(who, we, addr, wdat, gc, lat, err, rd, oa, srd, swr, ca, cd);
            if (we && !oor) ref_mem[addr] = wdat;
            n_tests++;
            if (lat !== elat || err !== oor || rd !== erd || oa !== 0) begin
                n_fail++; $display("FAIL rand_resp[%0d]: got lat=%0d err=%b data=%h other=%b required %0d %b %h 0",
                                   i, lat, err, rd, oa, elat, oor, erd);
            end
            n_tests++;
            if (swr !== (we && !oor) || srd !== (!we && !oor) ||
                (!oor && ca !== addr) || (we && !oor && cd !== wdat)) begin
                n_fail++; $display("FAIL rand_cmd[%0d]: got wr=%b rd=%b a=%h d=%h required %b %b %h %h",
                                   i, swr, srd, ca, cd, we && !oor, !we && !oor, addr, wdat);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_out_of_range();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
